// File: rtl/shared_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shared_vram_arbiter
// Description : Arbitrates CPU A and CPU B accesses to the shared video-RAM
//               window. Drives AB_Sel into the downstream VRAM chip-select /
//               VA12 decoder (0 = CPU A, 1 = CPU B) and stalls the losing Z80
//               through its WAITn pin until it owns the bus.
//
// Parameters  : TURN_CYCLES  dead clk cycles (0..3) between one owner
//                            releasing and the next owner being granted
//
// Ports       : clk      in   system clock, all state on rising edge
//               RESETn   in   asynchronous active-low reset
//               AMRn     in   CPU A MREQn
//               A_addr   in   CPU A address bits [15:11]
//               BMRn     in   CPU B MREQn
//               B_addr   in   CPU B address bits [15:11]
//               AB_Sel   out  registered bus owner select (0=A, 1=B)
//               A_WAITn  out  CPU A wait, active low
//               B_WAITn  out  CPU B wait, active low
//               busy     out  high while a CPU owns the bus
//
// Build macro : ARB_FIXED_PRIO_EN - when defined, ties always go to CPU A;
//               otherwise ties are broken round-robin on the last owner.
//
// Revision    : 1.0  initial release
// ============================================================================
module shared_vram_arbiter #(
    parameter int unsigned TURN_CYCLES = 1
) (
    input  logic       clk,
    input  logic       RESETn,
    input  logic       AMRn,
    input  logic [4:0] A_addr,
    input  logic       BMRn,
    input  logic [4:0] B_addr,
    output logic       AB_Sel,
    output logic       A_WAITn,
    output logic       B_WAITn,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2,
        ST_TURN  = 2'd3
    } state_t;

    // With no dead time the release edge arbitrates directly.
    localparam bit         c_NO_TURN   = (TURN_CYCLES == 0);
    localparam logic [1:0] c_TURN_LOAD = c_NO_TURN ? 2'd0 : 2'(TURN_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_last;        // 0 = A was last owner, 1 = B
    logic       w_last_nxt;
    logic [1:0] r_tcnt;
    logic [1:0] w_tcnt_nxt;
    logic       r_ab_sel;
    logic       w_ab_sel_nxt;
    logic       w_arb;

    logic       w_a_req;
    logic       w_b_req;
    logic       w_tie_to_a;
    logic       w_pick_a;
    logic       w_pick_b;

    // ------------------------------------------------------------------
    // Window decode
    //   A : D000-FFFF
    //   B : C800-EFFF and F800-FFFF (F000-F7FF is not shared for B)
    // ------------------------------------------------------------------
    assign w_a_req = ~AMRn & (A_addr >= 5'h1A);
    assign w_b_req = ~BMRn & (((B_addr >= 5'h19) && (B_addr <= 5'h1D)) ||
                              (B_addr == 5'h1F));

    // ------------------------------------------------------------------
    // Tie-break. Only the IDLE/TURN arbitration point can see a tie; a
    // releasing owner has dropped its own request so r_last is current.
    // ------------------------------------------------------------------
`ifdef ARB_FIXED_PRIO_EN
    assign w_tie_to_a = 1'b1;
`else
    assign w_tie_to_a = r_last;
`endif

    assign w_pick_a = w_a_req & (~w_b_req | w_tie_to_a);
    assign w_pick_b = w_b_req & ~w_pick_a;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            r_state  <= ST_IDLE;
            r_last   <= 1'b1;   // A wins the first tie
            r_tcnt   <= 2'd0;
            r_ab_sel <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_last   <= w_last_nxt;
            r_tcnt   <= w_tcnt_nxt;
            r_ab_sel <= w_ab_sel_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_last_nxt   = r_last;
        w_tcnt_nxt   = r_tcnt;
        w_ab_sel_nxt = r_ab_sel;
        w_arb        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_arb = 1'b1;
            end

            // Owners are never preempted; only their own release (MREQn
            // high or address leaving the window) ends the tenure.
            ST_OWN_A: begin
                if (!w_a_req) begin
                    w_last_nxt = 1'b0;
                    if (c_NO_TURN) begin
                        w_arb = 1'b1;
                    end else begin
                        w_state_nxt = ST_TURN;
                        w_tcnt_nxt  = c_TURN_LOAD;
                    end
                end
            end

            ST_OWN_B: begin
                if (!w_b_req) begin
                    w_last_nxt = 1'b1;
                    if (c_NO_TURN) begin
                        w_arb = 1'b1;
                    end else begin
                        w_state_nxt = ST_TURN;
                        w_tcnt_nxt  = c_TURN_LOAD;
                    end
                end
            end

            ST_TURN: begin
                if (r_tcnt == 2'd0) begin
                    w_arb = 1'b1;
                end else begin
                    w_tcnt_nxt = r_tcnt - 2'd1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Common arbitration point; AB_Sel moves only on a grant edge.
        if (w_arb) begin
            if (w_pick_a) begin
                w_state_nxt  = ST_OWN_A;
                w_ab_sel_nxt = 1'b0;
            end else if (w_pick_b) begin
                w_state_nxt  = ST_OWN_B;
                w_ab_sel_nxt = 1'b1;
            end else begin
                w_state_nxt  = ST_IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. WAITn is held inactive while in reset so neither Z80 is
    // stalled by a reset in progress.
    // ------------------------------------------------------------------
    assign AB_Sel  = r_ab_sel;
    assign busy    = (r_state == ST_OWN_A) || (r_state == ST_OWN_B);
    assign A_WAITn = ~RESETn | ~(w_a_req & (r_state != ST_OWN_A));
    assign B_WAITn = ~RESETn | ~(w_b_req & (r_state != ST_OWN_B));

endmodule
`default_nettype wire
